// File: rtl/conv_pair_feeder_if.sv
// Bus bundle for conv_pair_feeder: the sample input handshake, the flush
// strobe, and the pair outputs that feed CONV_iData0/CONV_iData1.
// Samples are DATA_W-bit two's complement and are carried bit-exact.
interface conv_pair_feeder_if #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 8
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic              flush;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] pair_data0;
  logic [DATA_W-1:0] pair_data1;
  logic              pair_valid;
  logic [CNT_W-1:0]  fifo_count;

  // Upstream producer / CONV side: drives samples and flush, observes pairs.
  modport master (
    output flush, in_data, in_valid,
    input  in_ready, pair_data0, pair_data1, pair_valid, fifo_count
  );

  // The feeder itself.
  modport slave (
    input  flush, in_data, in_valid,
    output in_ready, pair_data0, pair_data1, pair_valid, fifo_count
  );
endinterface

// File: rtl/conv_pair_feeder.sv
// conv_pair_feeder: buffers a sample stream in a small FIFO and presents
// consecutive pairs (x[n], x[n-1]) to CONV, holding each pair for
// HOLD_CYCLES clocks. The first sample after reset or flush only seeds the
// history register; pairs start with the second sample.
module conv_pair_feeder #(
  parameter int DATA_W      = 8,
  parameter int FIFO_DEPTH  = 8,
  parameter int HOLD_CYCLES = 3
) (
  input logic               clk,
  input logic               reset,
  conv_pair_feeder_if.slave bus
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(FIFO_DEPTH);
  localparam logic [HOLD_W-1:0] HOLD_LOAD  = HOLD_W'(HOLD_CYCLES - 1);

  // Sequencer states: PRIME seeds history, IDLE waits for data, HOLD keeps
  // the current pair on the outputs.
  localparam logic [1:0] S_PRIME = 2'd0;
  localparam logic [1:0] S_IDLE  = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q,     wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q,     rd_ptr_d;
  logic [CNT_W-1:0]  count_q,      count_d;
  logic [1:0]        state_q,      state_d;
  logic [HOLD_W-1:0] hold_cnt_q,   hold_cnt_d;
  logic [DATA_W-1:0] prev_q,       prev_d;
  logic [DATA_W-1:0] pair_data0_q, pair_data0_d;
  logic [DATA_W-1:0] pair_data1_q, pair_data1_d;
  logic              pair_valid_q, pair_valid_d;

  // ---------------------------------------------------------------------
  // Handshake and FIFO control
  // ---------------------------------------------------------------------
  logic              in_ready;
  logic              fifo_empty;
  logic              slot_free;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] pop_data;

  // Ready only looks at the registered count, so a pop in the same cycle
  // never opens a slot for a write into a full FIFO.
  assign in_ready   = !reset && (count_q != FULL_COUNT);
  assign fifo_empty = (count_q == '0);

  // The sequencer can take a sample whenever it is not mid-hold.
  assign slot_free = (state_q == S_PRIME) || (state_q == S_IDLE) ||
                     ((state_q == S_HOLD) && (hold_cnt_q == '0));

  // Flush wins over both sides of the FIFO.
  assign push = bus.in_valid && in_ready && !bus.flush;
  assign pop  = !bus.flush && !fifo_empty && slot_free;

  // The read port only sees entries written on an earlier edge, so there is
  // no same-cycle path from in_data to the pair outputs.
  assign pop_data = mem_q[rd_ptr_q];

  // Sample storage write port.
  // NOTE: the storage array has no reset; an entry is only read after it has
  // been written, and the pointers/count (which are reset) decide that.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.in_data;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic: pointers, count and the pair sequencer
  // ---------------------------------------------------------------------
  // Compute every _d from the current _q values and the pop/push decision.
  always_comb begin
    // NOTE: every _d gets a hold-value default first, so no branch can leave
    // one unassigned and infer a latch.
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    prev_d       = prev_q;
    pair_data0_d = pair_data0_q;
    pair_data1_d = pair_data1_q;
    pair_valid_d = pair_valid_q;

    if (bus.flush) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      state_d      = S_PRIME;
      hold_cnt_d   = '0;
      prev_d       = '0;
      pair_data0_d = '0;
      pair_data1_d = '0;
      pair_valid_d = 1'b0;
    end else begin
      // Pointers wrap naturally since FIFO_DEPTH is a power of two.
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

      // Simultaneous push and pop leave the count unchanged.
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);

      case (state_q)
        S_PRIME: begin
          // First sample only becomes history; nothing is presented yet.
          if (pop) begin
            prev_d  = pop_data;
            state_d = S_IDLE;
          end
        end

        S_IDLE: begin
          if (pop) begin
            pair_data0_d = pop_data;
            pair_data1_d = prev_q;
            prev_d       = pop_data;
            pair_valid_d = 1'b1;
            hold_cnt_d   = HOLD_LOAD;
            state_d      = S_HOLD;
          end else begin
            pair_valid_d = 1'b0;
          end
        end

        S_HOLD: begin
          if (hold_cnt_q != '0) begin
            hold_cnt_d = hold_cnt_q - HOLD_W'(1);
          end else if (pop) begin
            // Back-to-back reload: pair_valid never drops between pairs.
            pair_data0_d = pop_data;
            pair_data1_d = prev_q;
            prev_d       = pop_data;
            pair_valid_d = 1'b1;
            hold_cnt_d   = HOLD_LOAD;
            state_d      = S_HOLD;
          end else begin
            // Hold expired with nothing queued: drop valid, keep the data.
            pair_valid_d = 1'b0;
            state_d      = S_IDLE;
          end
        end

        default: begin
          state_d = S_PRIME;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  // Control and output registers; reset discards buffered samples and the
  // current pair.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      state_q      <= S_PRIME;
      hold_cnt_q   <= '0;
      prev_q       <= '0;
      pair_data0_q <= '0;
      pair_data1_q <= '0;
      pair_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values
      // regardless of statement order.
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      prev_q       <= prev_d;
      pair_data0_q <= pair_data0_d;
      pair_data1_q <= pair_data1_d;
      pair_valid_q <= pair_valid_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign bus.in_ready   = in_ready;
  assign bus.pair_data0 = pair_data0_q;
  assign bus.pair_data1 = pair_data1_q;
  assign bus.pair_valid = pair_valid_q;
  assign bus.fifo_count = count_q;

endmodule

// File: tb/tb_conv_pair_feeder.sv
// Self-checking bench for conv_pair_feeder. Two instances share stimulus:
// dut_a with HOLD_CYCLES=3 and dut_b with HOLD_CYCLES=1. Each is compared
// every clock against a queue-level reference model of the feeder.
module tb_conv_pair_feeder;

  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  conv_pair_feeder_if #(.DATA_W(8), .FIFO_DEPTH(DEPTH)) bus_a ();
  conv_pair_feeder_if #(.DATA_W(8), .FIFO_DEPTH(DEPTH)) bus_b ();

  conv_pair_feeder #(.DATA_W(8), .FIFO_DEPTH(DEPTH), .HOLD_CYCLES(3)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  conv_pair_feeder #(.DATA_W(8), .FIFO_DEPTH(DEPTH), .HOLD_CYCLES(1)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Reference model: a ring-buffer FIFO, a "have history" flag, the pair on
  // show and the number of clocks it still has to stay up.
  // ---------------------------------------------------------------------
  int          hold_of [2] = '{3, 1};
  logic [7:0]  m_buf  [2][DEPTH];
  int          m_head [2];
  int          m_size [2];
  bit          m_have_prev [2];
  logic [7:0]  m_prev [2];
  logic [7:0]  m_p0   [2];
  logic [7:0]  m_p1   [2];
  bit          m_valid [2];
  int          m_left [2];

  task automatic model_clear(input int d);
    m_head[d]      = 0;
    m_size[d]      = 0;
    m_have_prev[d] = 1'b0;
    m_prev[d]      = 8'h00;
    m_p0[d]        = 8'h00;
    m_p1[d]        = 8'h00;
    m_valid[d]     = 1'b0;
    m_left[d]      = 0;
  endtask

  task automatic model_edge(input int d, input bit v, input logic [7:0] x, input bit f);
    bit         ready;
    logic [7:0] s;
    if (f) begin
      model_clear(d);
      return;
    end
    ready = (m_size[d] != DEPTH);
    if (m_valid[d] && m_left[d] > 1) begin
      m_left[d]--;
    end else if (m_size[d] != 0) begin
      s         = m_buf[d][m_head[d]];
      m_head[d] = (m_head[d] + 1) % DEPTH;
      m_size[d]--;
      if (!m_have_prev[d]) begin
        m_prev[d]      = s;
        m_have_prev[d] = 1'b1;
      end else begin
        m_p1[d]    = m_prev[d];
        m_p0[d]    = s;
        m_prev[d]  = s;
        m_valid[d] = 1'b1;
        m_left[d]  = hold_of[d];
      end
    end else begin
      m_valid[d] = 1'b0;
    end
    if (v && ready) begin
      m_buf[d][(m_head[d] + m_size[d]) % DEPTH] = x;
      m_size[d]++;
    end
  endtask

  task automatic compare_one(input string tag, input int d,
                             input logic [7:0] p0, input logic [7:0] p1,
                             input logic pv, input logic [3:0] cnt, input logic rdy);
    check({tag, ".pair_data0"}, 32'(p0),  32'(m_p0[d]));
    check({tag, ".pair_data1"}, 32'(p1),  32'(m_p1[d]));
    check({tag, ".pair_valid"}, 32'(pv),  32'(m_valid[d]));
    check({tag, ".fifo_count"}, 32'(cnt), 32'(m_size[d]));
    check({tag, ".in_ready"},   32'(rdy), 32'(!reset && (m_size[d] != DEPTH)));
  endtask

  task automatic compare_all();
    compare_one("a", 0, bus_a.pair_data0, bus_a.pair_data1, bus_a.pair_valid,
                bus_a.fifo_count, bus_a.in_ready);
    compare_one("b", 1, bus_b.pair_data0, bus_b.pair_data1, bus_b.pair_valid,
                bus_b.fifo_count, bus_b.in_ready);
  endtask

  // Log of distinct pairs shown by dut_a while logging is enabled.
  logic [15:0] pair_log [$];
  bit          log_en  = 1'b0;
  logic        last_v  = 1'b0;
  logic [7:0]  last_p0 = 8'h00;

  // One clock: drive inputs, advance the model at the edge, compare 1 ns later.
  task automatic step(input bit v, input logic [7:0] x, input bit f);
    bus_a.in_valid = v;  bus_a.in_data = x;  bus_a.flush = f;
    bus_b.in_valid = v;  bus_b.in_data = x;  bus_b.flush = f;
    @(posedge clk);
    model_edge(0, v, x, f);
    model_edge(1, v, x, f);
    #1;
    compare_all();
    if (log_en && bus_a.pair_valid && (!last_v || bus_a.pair_data0 != last_p0))
      pair_log.push_back({bus_a.pair_data0, bus_a.pair_data1});
    last_v  = bus_a.pair_valid;
    last_p0 = bus_a.pair_data0;
  endtask

  initial begin
    int          idx;
    int          cyc;
    bit          acc;
    bit          saw_full;
    logic [15:0] exp_pair;

    reset = 1'b1;
    bus_a.in_valid = 1'b0; bus_a.in_data = 8'h00; bus_a.flush = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.in_data = 8'h00; bus_b.flush = 1'b0;
    model_clear(0);
    model_clear(1);
    #1;
    compare_all();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1 compare_all();

    // Three samples, HOLD=3: (20,10) for 3 clocks, (30,20) for 3, then idle.
    step(1, 8'd10, 0);
    step(1, 8'd20, 0);
    step(1, 8'd30, 0);
    check("t1.first_pair", {bus_a.pair_valid, bus_a.pair_data0, bus_a.pair_data1},
          {1'b1, 8'd20, 8'd10});
    repeat (3) step(0, 8'h00, 0);
    check("t1.second_pair", {bus_a.pair_valid, bus_a.pair_data0, bus_a.pair_data1},
          {1'b1, 8'd30, 8'd20});
    repeat (3) step(0, 8'h00, 0);
    check("t1.drop_valid", 32'(bus_a.pair_valid), 32'd0);

    // Extremes pass bit-exact.
    step(0, 8'h00, 1);
    step(1, 8'h80, 0);
    step(1, 8'h7F, 0);
    step(0, 8'h00, 0);
    check("t3.extremes", {bus_a.pair_data0, bus_a.pair_data1}, {8'h7F, 8'h80});

    // Flush mid-hold, then 5,6: outputs clear, then (6,5), no stale 20.
    step(0, 8'h00, 1);
    step(1, 8'd10, 0);
    step(1, 8'd20, 0);
    step(0, 8'h00, 0);
    step(1, 8'd99, 1);
    check("t4.flushed", {bus_a.pair_valid, bus_a.pair_data0, bus_a.pair_data1, bus_a.fifo_count},
          {1'b0, 8'd0, 8'd0, 4'd0});
    step(1, 8'd5, 0);
    step(1, 8'd6, 0);
    step(0, 8'h00, 0);
    check("t4.after_flush", {bus_a.pair_valid, bus_a.pair_data0, bus_a.pair_data1},
          {1'b1, 8'd6, 8'd5});

    // HOLD=1 instance: 1,2,3,4 back-to-back give three consecutive pairs.
    step(0, 8'h00, 1);
    step(1, 8'd1, 0);
    step(1, 8'd2, 0);
    step(1, 8'd3, 0);
    check("t6.pair0", {bus_b.pair_valid, bus_b.pair_data0, bus_b.pair_data1}, {1'b1, 8'd2, 8'd1});
    step(1, 8'd4, 0);
    check("t6.pair1", {bus_b.pair_valid, bus_b.pair_data0, bus_b.pair_data1}, {1'b1, 8'd3, 8'd2});
    step(0, 8'h00, 0);
    check("t6.pair2", {bus_b.pair_valid, bus_b.pair_data0, bus_b.pair_data1}, {1'b1, 8'd4, 8'd3});
    step(0, 8'h00, 0);
    check("t6.drained", 32'(bus_b.pair_valid), 32'd0);

    // Ramp 0..39 with in_valid held high: FIFO fills, pairs arrive in order.
    step(0, 8'h00, 1);
    pair_log.delete();
    log_en   = 1'b1;
    idx      = 0;
    cyc      = 0;
    saw_full = 1'b0;
    while (idx < 40 && cyc < 400) begin
      acc = bus_a.in_ready;
      step(1, 8'(idx), 0);
      if (acc) idx++;
      if (bus_a.fifo_count == 4'd8 && !bus_a.in_ready) saw_full = 1'b1;
      cyc++;
    end
    check("t2.accepted", 32'(idx), 32'd40);
    check("t2.full_seen", 32'(saw_full), 32'd1);
    repeat (40) step(0, 8'h00, 0);
    log_en = 1'b0;
    check("t2.pair_total", 32'(pair_log.size()), 32'd39);
    for (int i = 0; i < pair_log.size() && i < 39; i++) begin
      exp_pair = {8'(i + 1), 8'(i)};
      check("t2.pair", 32'(pair_log[i]), 32'(exp_pair));
    end

    // Asynchronous reset mid-hold with four samples queued.
    step(0, 8'h00, 1);
    for (int k = 0; k < 7; k++) step(1, 8'(8'd50 + 8'(k)), 0);
    check("t5.count_before", 32'(bus_a.fifo_count), 32'd4);
    check("t5.valid_before", 32'(bus_a.pair_valid), 32'd1);
    bus_a.in_valid = 1'b0; bus_b.in_valid = 1'b0;
    #2 reset = 1'b1;
    model_clear(0);
    model_clear(1);
    #1;
    check("t5.async_clear", {bus_a.pair_valid, bus_a.pair_data0, bus_a.pair_data1,
                             bus_a.fifo_count, bus_a.in_ready},
          {1'b0, 8'd0, 8'd0, 4'd0, 1'b0});
    compare_all();
    @(posedge clk);
    #1 reset = 1'b0;
    #1 compare_all();
    // After release the first sample must only seed history again.
    step(1, 8'd7, 0);
    step(1, 8'd8, 0);
    step(0, 8'h00, 0);
    check("t5.reprime", {bus_a.pair_valid, bus_a.pair_data0, bus_a.pair_data1}, {1'b1, 8'd8, 8'd7});

    // Randomized traffic with occasional flushes.
    for (int n = 0; n < 1500; n++) begin
      step(($urandom_range(0, 3) != 0) ^ (n[8] & ($urandom_range(0, 1) == 1)),
           8'($urandom), ($urandom_range(0, 99) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
